// File: rtl/if_stage.sv
// Instruction fetch stage. Issues one imem request at a time, fills the IF/ID
// register and parks one extra word in a skid buffer while decode is stalled.
module if_stage #(
   parameter int unsigned      WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_0000)
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             imem_req_valid,
   output logic [WIDTH-1:0] imem_req_addr,
   input  logic             imem_req_ready,
   input  logic             imem_resp_valid,
   input  logic [31:0]      imem_resp_data,
   input  logic             stall,
   input  logic             redirect,
   input  logic [WIDTH-1:0] redirect_pc,
   output logic [31:0]      instruction,
   output logic [WIDTH-1:0] pc_out,
   output logic             valid_out
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [2:0] {IDLE, FETCH, WAIT, HOLD, DRAIN} state_t;

   state_t           state;
   logic [WIDTH-1:0] pc;
   logic             skid_vld;
   logic [31:0]      skid_instr;
   logic [WIDTH-1:0] skid_pc;
   logic             slot_free;

   function automatic logic [WIDTH-1:0] pc_inc(input logic [WIDTH-1:0] a);
      return a + WIDTH'(4);
   endfunction

   function automatic logic [WIDTH-1:0] pc_align(input logic [WIDTH-1:0] a);
      return {a[WIDTH-1:2], 2'b00};
   endfunction

   assign imem_req_addr = pc;
   assign slot_free     = !valid_out || !stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         pc             <= RESET_PC;
         imem_req_valid <= 1'b0;
         valid_out      <= 1'b0;
         instruction    <= NOP;
         pc_out         <= RESET_PC;
         skid_vld       <= 1'b0;
         skid_instr     <= NOP;
         skid_pc        <= RESET_PC;
      end else begin
         // Decode takes the IF/ID word on any unstalled edge; a reload below overrides.
         if (valid_out && !stall)
            valid_out <= 1'b0;

         if (redirect) begin
            pc        <= pc_align(redirect_pc);
            valid_out <= 1'b0;
            skid_vld  <= 1'b0;
            case (state)
               FETCH: begin
                  // A request accepted this very edge still has a response coming back.
                  if (imem_req_ready) begin
                     state          <= DRAIN;
                     imem_req_valid <= 1'b0;
                  end else begin
                     state          <= FETCH;
                     imem_req_valid <= 1'b1;
                  end
               end
               WAIT, DRAIN: begin
                  if (imem_resp_valid) begin
                     state          <= FETCH;
                     imem_req_valid <= 1'b1;
                  end else begin
                     state          <= DRAIN;
                     imem_req_valid <= 1'b0;
                  end
               end
               default: begin
                  state          <= FETCH;
                  imem_req_valid <= 1'b1;
               end
            endcase
         end else begin
            case (state)
               IDLE: begin
                  state          <= FETCH;
                  imem_req_valid <= 1'b1;
               end
               FETCH: begin
                  if (imem_req_ready) begin
                     state          <= WAIT;
                     imem_req_valid <= 1'b0;
                  end
               end
               WAIT: begin
                  if (imem_resp_valid) begin
                     pc <= pc_inc(pc);
                     if (slot_free) begin
                        instruction    <= imem_resp_data;
                        pc_out         <= pc;
                        valid_out      <= 1'b1;
                        state          <= FETCH;
                        imem_req_valid <= 1'b1;
                     end else begin
                        skid_vld   <= 1'b1;
                        skid_instr <= imem_resp_data;
                        skid_pc    <= pc;
                        state      <= HOLD;
                     end
                  end
               end
               HOLD: begin
                  if (!stall && skid_vld) begin
                     instruction    <= skid_instr;
                     pc_out         <= skid_pc;
                     valid_out      <= 1'b1;
                     skid_vld       <= 1'b0;
                     state          <= FETCH;
                     imem_req_valid <= 1'b1;
                  end
               end
               DRAIN: begin
                  if (imem_resp_valid) begin
                     state          <= FETCH;
                     imem_req_valid <= 1'b1;
                  end
               end
               default: begin
                  state          <= IDLE;
                  imem_req_valid <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus random memory/stall/redirect
// traffic checked against an in-order program-counter reference model.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] instruction;
   logic [31:0] pc_out;
   logic        valid_out;

   logic        w_req_valid;
   logic [31:0] w_req_addr;
   logic [31:0] w_instruction;
   logic [31:0] w_pc_out;
   logic        w_valid_out;

   int errors = 0;
   int checks = 0;

   // memory model and reference state
   int          mem_cnt = 0;
   logic [31:0] mem_addr = '0;
   bit          outstanding = 0;
   logic [31:0] exp_pc = '0;
   int          consumed = 0;

   // stimulus knobs
   int          lat_min = 1, lat_max = 1;
   int          rdy_pct = 100, stall_pct = 0, redir_pct = 0;
   bit          use_force_stall = 0, force_stall = 0;
   bit          force_redir = 0, hold_ready0 = 0;
   logic [31:0] force_rpc = '0;

   always #5 clk = ~clk;

   if_stage #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .imem_req_valid  (imem_req_valid),
      .imem_req_addr   (imem_req_addr),
      .imem_req_ready  (imem_req_ready),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .stall           (stall),
      .redirect        (redirect),
      .redirect_pc     (redirect_pc),
      .instruction     (instruction),
      .pc_out          (pc_out),
      .valid_out       (valid_out)
   );

   if_stage #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk             (clk),
      .rst_n           (rst_n),
      .imem_req_valid  (w_req_valid),
      .imem_req_addr   (w_req_addr),
      .imem_req_ready  (1'b1),
      .imem_resp_valid (1'b1),
      .imem_resp_data  (32'h1234_5678),
      .stall           (1'b0),
      .redirect        (1'b0),
      .redirect_pc     (32'h0000_0000),
      .instruction     (w_instruction),
      .pc_out          (w_pc_out),
      .valid_out       (w_valid_out)
   );

   function automatic logic [31:0] word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, run the memory model, advance, check the edge.
   task automatic cycle();
      logic        p_rstn, p_rv, p_vo, p_stall, p_rdy, p_redir;
      logic [31:0] p_addr, p_instr, p_pc, p_rpc;
      stall          = use_force_stall ? force_stall : ($urandom_range(99) < stall_pct);
      imem_req_ready = hold_ready0 ? 1'b0 : ($urandom_range(99) < rdy_pct);
      redirect       = force_redir ? 1'b1 : ($urandom_range(99) < redir_pct);
      redirect_pc    = force_redir ? force_rpc : 32'($urandom_range(1023));
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
      if (mem_cnt > 0) begin
         mem_cnt--;
         if (mem_cnt == 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = word(mem_addr);
            outstanding     = 0;
         end
      end
      p_rstn  = rst_n;
      p_rv    = imem_req_valid;
      p_vo    = valid_out;
      p_stall = stall;
      p_rdy   = imem_req_ready;
      p_redir = redirect;
      p_addr  = imem_req_addr;
      p_instr = instruction;
      p_pc    = pc_out;
      p_rpc   = redirect_pc;
      if (p_rstn && p_rv) check("one_outstanding", outstanding, 0);
      @(posedge clk);
      #1;
      if (p_rstn && rst_n) begin
         if (p_vo && !p_stall) begin
            check("order_pc", p_pc, exp_pc);
            check("order_word", p_instr, word(p_pc));
            exp_pc = exp_pc + 32'd4;
            consumed++;
         end
         if (p_redir) begin
            exp_pc = p_rpc & ~32'h3;
            check("redir_kill", valid_out, 0);
            check("redir_pc", imem_req_addr, p_rpc & ~32'h3);
         end else begin
            if (p_vo && p_stall) begin
               check("stall_vld", valid_out, 1);
               check("stall_instr", instruction, p_instr);
               check("stall_pc", pc_out, p_pc);
            end
            if (p_rv && !p_rdy) begin
               check("req_hold_vld", imem_req_valid, 1);
               check("req_hold_addr", imem_req_addr, p_addr);
            end
         end
         if (p_rv && p_rdy) begin
            outstanding = 1;
            mem_cnt     = int'($urandom_range(lat_max, lat_min));
            mem_addr    = p_addr;
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
      imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
      cycle();
      cycle();
      check("rst_req_valid", imem_req_valid, 0);
      check("rst_valid_out", valid_out, 0);
      check("rst_instr", instruction, 32'h0000_0013);
      check("rst_pc_out", pc_out, 32'h0);
      check("rst_addr", imem_req_addr, 32'h0);
      check("wrap_rst_pc_out", w_pc_out, 32'hFFFF_FFFC);

      // Zero-wait memory, no stalls
      rst_n = 1'b1;
      exp_pc = 32'h0;
      cycle();
      check("zw_e1_req", imem_req_valid, 1);
      check("zw_e1_addr", imem_req_addr, 32'h0);
      check("zw_e1_vld", valid_out, 0);
      check("wrap_first_addr", w_req_addr, 32'hFFFF_FFFC);
      cycle();
      check("zw_e2_req", imem_req_valid, 0);
      check("zw_e2_vld", valid_out, 0);
      cycle();
      check("zw_e3_vld", valid_out, 1);
      check("zw_e3_pc", pc_out, 32'h0);
      check("zw_e3_word", instruction, word(32'h0));
      check("wrap_second_req", w_req_valid, 1);
      check("wrap_second_addr", w_req_addr, 32'h0000_0000);
      check("wrap_pc_out", w_pc_out, 32'hFFFF_FFFC);
      check("wrap_instr", w_instruction, 32'h1234_5678);
      for (int e = 4; e <= 7; e++) begin
         cycle();
         check("zw_pulse", valid_out, e % 2);
         if (e % 2 == 1) check("zw_pc", pc_out, 32'((e - 3) * 2));
      end

      // Decode stall for 5 cycles with pc_out = 0x8
      use_force_stall = 1; force_stall = 1;
      for (int i = 0; i < 5; i++) begin
         cycle();
         check("stall5_vld", valid_out, 1);
         check("stall5_pc", pc_out, 32'h8);
         check("stall5_no_req", imem_req_valid, 0);
         if (i >= 1) check("stall5_next_pc", imem_req_addr, 32'h10);
      end
      force_stall = 0;
      cycle();
      check("unstall_vld", valid_out, 1);
      check("unstall_pc", pc_out, 32'hC);
      check("unstall_word", instruction, word(32'hC));
      check("unstall_req", imem_req_valid, 1);
      check("unstall_addr", imem_req_addr, 32'h10);
      use_force_stall = 0;

      // Redirect in WAIT before the response arrives
      lat_min = 2; lat_max = 2;
      cycle();
      check("drn_wait_req", imem_req_valid, 0);
      force_redir = 1; force_rpc = 32'h103;
      cycle();
      force_redir = 0;
      check("drn_addr", imem_req_addr, 32'h100);
      check("drn_no_req", imem_req_valid, 0);
      check("drn_vld", valid_out, 0);
      cycle();
      check("drn_refetch_req", imem_req_valid, 1);
      check("drn_refetch_addr", imem_req_addr, 32'h100);
      check("drn_stale_drop", valid_out, 0);
      cycle();
      check("drn_wait_vld1", valid_out, 0);
      cycle();
      check("drn_wait_vld2", valid_out, 0);
      cycle();
      check("drn_target_vld", valid_out, 1);
      check("drn_target_pc", pc_out, 32'h100);
      check("drn_target_word", instruction, word(32'h100));

      // Redirect while stalled with the skid buffer occupied
      lat_min = 1; lat_max = 1;
      use_force_stall = 1; force_stall = 1;
      cycle();
      cycle();
      check("hold_no_req", imem_req_valid, 0);
      check("hold_pc", pc_out, 32'h100);
      force_redir = 1; force_rpc = 32'h200;
      cycle();
      force_redir = 0;
      check("hold_redir_vld", valid_out, 0);
      check("hold_redir_req", imem_req_valid, 1);
      check("hold_redir_addr", imem_req_addr, 32'h200);
      force_stall = 0;
      cycle();
      cycle();
      check("hold_resume_vld", valid_out, 1);
      check("hold_resume_pc", pc_out, 32'h200);
      check("hold_resume_word", instruction, word(32'h200));
      use_force_stall = 0;

      // Reset pulse while a response is still outstanding
      lat_min = 3; lat_max = 3;
      cycle();
      #2 rst_n = 1'b0;
      #1;
      check("arst_req", imem_req_valid, 0);
      check("arst_vld", valid_out, 0);
      check("arst_instr", instruction, 32'h0000_0013);
      check("arst_pc_out", pc_out, 32'h0);
      check("arst_addr", imem_req_addr, 32'h0);
      outstanding = 0;
      exp_pc = 32'h0;
      cycle();
      rst_n = 1'b1;
      hold_ready0 = 1;
      cycle();
      check("arst_fetch_addr", imem_req_addr, 32'h0);
      cycle();
      check("late_resp_ignored", valid_out, 0);
      check("late_resp_req", imem_req_valid, 1);
      check("late_resp_addr", imem_req_addr, 32'h0);
      hold_ready0 = 0;
      lat_min = 1; lat_max = 1;
      cycle();
      check("arst_wait_vld", valid_out, 0);
      cycle();
      check("arst_first_vld", valid_out, 1);
      check("arst_first_pc", pc_out, 32'h0);
      check("arst_first_word", instruction, word(32'h0));

      // Random traffic against the reference model
      lat_min = 1; lat_max = 3;
      rdy_pct = 70; stall_pct = 30; redir_pct = 4;
      consumed = 0;
      for (int i = 0; i < 3000; i++) cycle();
      check("progress", consumed >= 100, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
